// File: rtl/fpu_issue_queue_if.sv
// Decode-to-FPU-to-writeback bundle for fpu_issue_queue.
// The slave modport is the queue's view; master is the surrounding core/FPU.
interface fpu_issue_queue_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);
  logic                   enq_valid;
  logic                   enq_ready;
  logic [31:0]            enq_a;
  logic [31:0]            enq_b;
  logic [6:0]             enq_funct7;
  logic [2:0]             enq_funct3;
  logic                   enq_rs2b0;
  logic [TAG_W-1:0]       enq_rd;

  logic                   fpu_valid;
  logic                   fpu_ready;
  logic [31:0]            fpu_a;
  logic [31:0]            fpu_b;
  logic [6:0]             fpu_funct7;
  logic [2:0]             fpu_funct3;
  logic                   fpu_rs2b0;
  logic [31:0]            fpu_r;

  logic                   wb_valid;
  logic                   wb_ready;
  logic [TAG_W-1:0]       wb_rd;
  logic [31:0]            wb_data;

  logic                   flush;
  logic [$clog2(DEPTH):0] occupancy;

  modport slave (
    input  enq_valid, enq_a, enq_b, enq_funct7, enq_funct3, enq_rs2b0, enq_rd,
    input  fpu_ready, fpu_r, wb_ready, flush,
    output enq_ready, fpu_valid, fpu_a, fpu_b, fpu_funct7, fpu_funct3, fpu_rs2b0,
    output wb_valid, wb_rd, wb_data, occupancy
  );

  modport master (
    output enq_valid, enq_a, enq_b, enq_funct7, enq_funct3, enq_rs2b0, enq_rd,
    output fpu_ready, fpu_r, wb_ready, flush,
    input  enq_ready, fpu_valid, fpu_a, fpu_b, fpu_funct7, fpu_funct3, fpu_rs2b0,
    input  wb_valid, wb_rd, wb_data, occupancy
  );
endinterface

// File: rtl/fpu_issue_queue.sv
// In-order FPU issue FIFO + 2-entry result FIFO; enq->fpu_valid 1 cycle, fpu_ready->wb_valid 1 cycle.
// Backpressure: enq_ready drops when full or flushing; issue stalls unless a result slot is guaranteed.
module fpu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input logic              clock,
  input logic              reset_n,
  fpu_issue_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [6:0]       funct7;
    logic [2:0]       funct3;
    logic             rs2b0;
    logic [TAG_W-1:0] rd;
  } entry_t;

  typedef struct packed {
    logic [TAG_W-1:0] rd;
    logic [31:0]      data;
  } result_t;

  typedef enum logic {IDLE, EXEC} state_t;

  entry_t  iq [DEPTH];
  result_t rq [2];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_next;
  logic          rq_wr, rq_rd;
  logic [1:0]    rcnt, rcnt_next;
  state_t        state, state_next;

  logic   enq_ready, enq_fire, complete, wb_pop, can_issue, fpu_valid;
  entry_t head;
  entry_t enq_entry;

  assign head      = iq[rd_ptr];
  assign enq_entry = '{a: bus.enq_a, b: bus.enq_b, funct7: bus.enq_funct7,
                       funct3: bus.enq_funct3, rs2b0: bus.enq_rs2b0, rd: bus.enq_rd};

  assign enq_ready = (cnt != CW'(DEPTH)) && !bus.flush;
  assign enq_fire  = bus.enq_valid && enq_ready;
  assign complete  = (state == EXEC) && bus.fpu_ready && !bus.flush;
  assign wb_pop    = (rcnt != 2'd0) && bus.wb_ready;

  assign cnt_next  = cnt + CW'(enq_fire) - CW'(complete);
  assign rcnt_next = rcnt + 2'(complete) - 2'(wb_pop);
  // Credit check: the op being issued must find a free result slot when it completes.
  assign can_issue = (cnt_next != '0) && (rcnt_next <= 2'd1);

  always_comb begin
    state_next = state;
    fpu_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush && can_issue) state_next = EXEC;
      end
      EXEC: begin
        fpu_valid = 1'b1;
        if (bus.flush)                  state_next = IDLE;
        else if (complete && !can_issue) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rq_wr  <= 1'b0;
      rq_rd  <= 1'b0;
      rcnt   <= '0;
    end else if (bus.flush) begin
      // Emptying by pointer equalisation; a completion in this cycle is dropped.
      rd_ptr <= wr_ptr;
      cnt    <= '0;
      rq_rd  <= rq_wr;
      rcnt   <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
      if (complete) rd_ptr <= rd_ptr + PW'(1);
      if (complete) rq_wr  <= ~rq_wr;
      if (wb_pop)   rq_rd  <= ~rq_rd;
      cnt  <= cnt_next;
      rcnt <= rcnt_next;
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire) iq[wr_ptr] <= enq_entry;
    if (complete) rq[rq_wr]  <= '{rd: head.rd, data: bus.fpu_r};
  end

  assign bus.enq_ready  = enq_ready;
  assign bus.fpu_valid  = fpu_valid;
  assign bus.fpu_a      = head.a;
  assign bus.fpu_b      = head.b;
  assign bus.fpu_funct7 = head.funct7;
  assign bus.fpu_funct3 = head.funct3;
  assign bus.fpu_rs2b0  = head.rs2b0;
  assign bus.wb_valid   = (rcnt != 2'd0);
  assign bus.wb_rd      = rq[rq_rd].rd;
  assign bus.wb_data    = rq[rq_rd].data;
  assign bus.occupancy  = cnt;
endmodule
